// File: rtl/code_loader_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : code_loader_ram_pkg
// Description : Shared state encodings and read-window byte ordering for the
//               code loader RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package code_loader_ram_pkg;

    localparam logic [0:0] c_LOADER_LOAD = 1'b0;
    localparam logic [0:0] c_LOADER_RUN  = 1'b1;

    typedef enum logic [0:0] {
        ST_LOAD = c_LOADER_LOAD,
        ST_RUN  = c_LOADER_RUN
    } loader_state_e;

    // Byte at addr lands in the most significant byte of the window.
    localparam bit c_WINDOW_MSB_FIRST = 1'b1;

    function automatic int window_slot(input int k, input int taps);
        return c_WINDOW_MSB_FIRST ? (taps - 1 - k) : k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_loader_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : code_loader_ram_if
// Description : Load-stream, CPU fetch and status signals of the code loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface code_loader_ram_if #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int EXTRA = 4
);
    logic [DW-1:0]              in_data;
    logic                       in_valid;
    logic                       in_last;
    logic                       in_ready;
    logic [AW:0]                addr;
    logic [EXTRA-1:0]           extra;
    logic [AW:0]                lower_bound;
    logic [AW:0]                upper_bound;
    logic [(2**EXTRA)*DW-1:0]   data;
    logic                       error;
    logic                       cpu_reset;
    logic                       loaded;
    logic [AW:0]                load_count;
    logic                       overflow;

    modport master (
        output in_data, in_valid, in_last, addr, extra, lower_bound, upper_bound,
        input  in_ready, data, error, cpu_reset, loaded, load_count, overflow
    );

    modport slave (
        input  in_data, in_valid, in_last, addr, extra, lower_bound, upper_bound,
        output in_ready, data, error, cpu_reset, loaded, load_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/code_loader_ram_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : byte_ram
// Description : Byte RAM with one synchronous write port and TAPS parallel
//               combinational read taps at consecutive addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_ram #(
    parameter int AW   = 6,
    parameter int DW   = 8,
    parameter int TAPS = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [DW-1:0]            i_wr_data,
    input  logic [AW-1:0]            i_rd_base,
    output logic [TAPS-1:0][DW-1:0]  o_rd_bytes
);
    localparam int c_DEPTH = 2**AW;

    logic [DW-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Taps past the end of memory wrap; the caller masks them as errors.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic [AW-1:0] w_idx;
        assign w_idx         = i_rd_base + AW'(k);
        assign o_rd_bytes[k] = r_mem[w_idx];
    end

endmodule
`default_nettype wire

// File: rtl/code_loader_ram.sv
`default_nettype none
// ============================================================================
// Module      : code_loader_ram
// Description : Loads a program byte stream into RAM, holds the CPU in reset
//               until done, then serves bounded multi-byte fetch windows.
//               Optional macro CODE_LOADER_RELOAD_EN adds a reload input.
// Revision    : 1.0 - initial release
// ============================================================================
module code_loader_ram
    import code_loader_ram_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef CODE_LOADER_RELOAD_EN
    input  logic                reload,
`endif
    code_loader_ram_if.slave    bus
);
    localparam int          c_DEPTH    = 2**AW;
    localparam int          c_TAPS     = 2**EXTRA;
    localparam logic [AW:0] c_DEPTH_W  = (AW+1)'(c_DEPTH);
    localparam logic [AW:0] c_LAST_PTR = (AW+1)'(c_DEPTH - 1);

    loader_state_e                 r_state, w_state_next;
    logic [AW:0]                   r_wr_ptr, w_wr_ptr_next;
    logic                          r_overflow, w_overflow_next;
    logic                          w_in_ready, w_wr_en, w_reload;
    logic [c_TAPS-1:0][DW-1:0]     w_taps, w_window, r_data;
    logic                          r_error, w_error;
    logic [AW+1:0]                 w_end;

`ifdef CODE_LOADER_RELOAD_EN
    assign w_reload = reload;
`else
    assign w_reload = 1'b0;
`endif

    assign w_in_ready = (r_state == ST_LOAD) && (r_wr_ptr < c_DEPTH_W);
    assign w_wr_en    = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_overflow <= w_overflow_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wr_ptr_next   = r_wr_ptr;
        w_overflow_next = r_overflow;
        case (r_state)
            ST_LOAD: begin
                if (w_wr_en) begin
                    w_wr_ptr_next = r_wr_ptr + (AW+1)'(1);
                    if (bus.in_last) begin
                        w_state_next = ST_RUN;
                    end else if (r_wr_ptr == c_LAST_PTR) begin
                        w_state_next    = ST_RUN;
                        w_overflow_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_reload) begin
                    w_state_next    = ST_LOAD;
                    w_wr_ptr_next   = '0;
                    w_overflow_next = 1'b0;
                end
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    byte_ram #(
        .AW   (AW),
        .DW   (DW),
        .TAPS (c_TAPS)
    ) u_byte_ram (
        .clk        (clk),
        .i_we       (w_wr_en),
        .i_wr_addr  (r_wr_ptr[AW-1:0]),
        .i_wr_data  (bus.in_data),
        .i_rd_base  (bus.addr[AW-1:0]),
        .o_rd_bytes (w_taps)
    );

    // One extra bit on the window end keeps addr+extra from wrapping.
    assign w_end   = {1'b0, bus.addr} + (AW+2)'(bus.extra);
    assign w_error = (r_state != ST_RUN)
                  || (bus.addr < bus.lower_bound)
                  || (w_end > {1'b0, bus.upper_bound})
                  || (w_end >= {1'b0, r_wr_ptr});

    always_comb begin
        w_window = '0;
        for (int k = 0; k < c_TAPS; k++) begin
            if (k <= int'(bus.extra)) begin
                w_window[window_slot(k, c_TAPS)] = w_taps[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_error <= 1'b0;
        end else begin
            r_data  <= w_error ? '0 : w_window;
            r_error <= w_error;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.data       = r_data;
    assign bus.error      = r_error;
    assign bus.cpu_reset  = (r_state != ST_RUN);
    assign bus.loaded     = (r_state == ST_RUN);
    assign bus.load_count = r_wr_ptr;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire
